// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with start-glitch rejection, frame/parity error strobes and an LED mirror.
// Optional parity bit after the data bits is enabled by defining UART_RX_PARITY_EN.
module uart_rx_param #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LED_W      = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter int unsigned PARITY_ODD = 0
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_uart,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_vld,
    output logic              frame_err,
    output logic              parity_err,
    output logic              busy,
    output logic [LED_W-1:0]  led
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
    localparam int unsigned HALF     = BAUD_DIV / 2;
    localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned BIT_W    = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SMP = CNT_W'(HALF - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state, state_nxt;
    logic              sync1, sync2, prev;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic [DATA_W-1:0] rx_data_nxt;
    logic [LED_W-1:0]  led_nxt;
    logic              vld_nxt, ferr_nxt;
    logic              line_c, start_edge_c, smp_c, par_bad_c;

`ifdef UART_RX_PARITY_EN
    logic              par_bit, par_bit_nxt, perr_nxt;
`endif

    assign line_c       = sync2;
    assign start_edge_c = ~sync2 & prev;
    assign smp_c        = (cnt == CNT_SMP);

`ifdef UART_RX_PARITY_EN
    // Even parity: data ^ parity reduces to 0; odd parity: reduces to 1.
    assign par_bad_c = ((^shift) ^ par_bit) != 1'(PARITY_ODD);
`else
    assign par_bad_c = 1'b0;
`endif

    // Next-state, datapath and strobe decode.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        rx_data_nxt = rx_data;
        led_nxt     = led;
        vld_nxt     = 1'b0;
        ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_nxt = par_bit;
        perr_nxt    = 1'b0;
`endif

        if (state != IDLE) begin
            cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                if (start_edge_c) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                if (smp_c) begin
                    if (line_c) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end
                end
            end
            DATA: begin
                if (smp_c) begin
                    shift_nxt[bit_cnt] = line_c;
                    if (bit_cnt == BIT_MAX) begin
                        bit_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
                        state_nxt   = PARITY;
`else
                        state_nxt   = STOP;
`endif
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (smp_c) begin
                    par_bit_nxt = line_c;
                    state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop so a following start bit is never missed.
                if (smp_c) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    ferr_nxt  = ~line_c;
`ifdef UART_RX_PARITY_EN
                    perr_nxt  = par_bad_c;
`endif
                    if (line_c && !par_bad_c) begin
                        vld_nxt     = 1'b1;
                        rx_data_nxt = shift;
                        led_nxt     = shift[LED_W-1:0];
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, synchroniser and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            prev      <= 1'b1;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            led       <= '0;
            rx_vld    <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            sync1     <= rx_uart;
            sync2     <= sync1;
            prev      <= sync2;
            cnt       <= cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            rx_data   <= rx_data_nxt;
            led       <= led_nxt;
            rx_vld    <= vld_nxt;
            frame_err <= ferr_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bit    <= par_bit_nxt;
            parity_err <= perr_nxt;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed frames, glitch/break/reset cases and random frames
// checked against a frame-level model (outcome per frame, held data, strobe latency).
module tb_uart_rx_param;

    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned BAUD     = 2_500_000;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned LED_W    = 2;
    localparam int unsigned BD       = CLK_FREQ / BAUD;
    localparam int unsigned H        = BD / 2;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NB       = DATA_W + 1;
`else
    localparam int unsigned NB       = DATA_W;
`endif
    localparam int unsigned LAT      = (NB + 1) * BD + H + 3;

    logic              clk;
    logic              rst_n;
    logic              rx_uart;
    logic [DATA_W-1:0] rx_data;
    logic              rx_vld;
    logic              frame_err;
    logic              parity_err;
    logic              busy;
    logic [LED_W-1:0]  led;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned n_vld = 0;
    int unsigned n_ferr = 0;
    int unsigned n_perr = 0;
    int unsigned vld_cyc = 0;
    int unsigned fall_cyc = 0;
    int unsigned s_vld, s_ferr, s_perr;
    logic [DATA_W-1:0] exp_data;

    uart_rx_param #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DATA_W   (DATA_W),
        .LED_W    (LED_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_uart    (rx_uart),
        .rx_data    (rx_data),
        .rx_vld     (rx_vld),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy),
        .led        (led)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_vld) begin
            n_vld++;
            vld_cyc = cyc;
        end
        if (frame_err)  n_ferr++;
        if (parity_err) n_perr++;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic snap();
        s_vld  = n_vld;
        s_ferr = n_ferr;
        s_perr = n_perr;
    endtask

    // Drive one frame; flip inverts the correct parity bit when parity is built in.
    task automatic send(input logic [DATA_W-1:0] d, input logic stop, input logic flip);
        snap();
        fall_cyc = cyc;
        rx_uart = 1'b0;
        tick(BD);
        for (int i = 0; i < int'(DATA_W); i++) begin
            rx_uart = d[i];
            tick(BD);
        end
`ifdef UART_RX_PARITY_EN
        rx_uart = (^d) ^ flip;
        tick(BD);
`endif
        rx_uart = stop;
        tick(BD);
    endtask

    // Frame-level model: expected strobes, held word and latency for the frame just sent.
    task automatic check_frame(input string tag, input logic [DATA_W-1:0] d,
                               input logic stop, input logic flip);
        logic perr_e;
        logic good;
`ifdef UART_RX_PARITY_EN
        perr_e = flip;
`else
        perr_e = 1'b0;
`endif
        good = stop && !perr_e;
        if (good) exp_data = d;
        chk({tag, ".vld"},  n_vld - s_vld, 32'(good));
        chk({tag, ".ferr"}, n_ferr - s_ferr, 32'(!stop));
        chk({tag, ".perr"}, n_perr - s_perr, 32'(perr_e));
        chk({tag, ".data"}, 32'(rx_data), 32'(exp_data));
        chk({tag, ".led"},  32'(led), 32'(exp_data[LED_W-1:0]));
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        if (good) chk({tag, ".lat"}, vld_cyc - fall_cyc, LAT);
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        logic              stop;
        logic              flip;
        logic              prev_stop;
        int unsigned       gap;

        rst_n    = 1'b0;
        rx_uart  = 1'b1;
        exp_data = '0;
        tick(10);
        chk("rst.data", 32'(rx_data), 32'd0);
        chk("rst.vld",  32'(rx_vld), 32'd0);
        chk("rst.ferr", 32'(frame_err), 32'd0);
        chk("rst.perr", 32'(parity_err), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.led",  32'(led), 32'd0);
        rst_n = 1'b1;
        tick(4);

        send(8'h55, 1'b1, 1'b0);
        check_frame("f55", 8'h55, 1'b1, 1'b0);

        // Back-to-back frames, zero idle gap.
        send(8'hA3, 1'b1, 1'b0);
        check_frame("fA3", 8'hA3, 1'b1, 1'b0);
        send(8'h3C, 1'b1, 1'b0);
        check_frame("f3C", 8'h3C, 1'b1, 1'b0);

        // Short low pulse shorter than half a bit: rejected as a glitch.
        snap();
        rx_uart = 1'b0;
        tick(5);
        chk("glitch.busy_hi", 32'(busy), 32'd1);
        rx_uart = 1'b1;
        tick(H - 1);
        chk("glitch.busy_lo", 32'(busy), 32'd0);
        chk("glitch.strobes", (n_vld - s_vld) + (n_ferr - s_ferr) + (n_perr - s_perr), 32'd0);
        send(8'h0F, 1'b1, 1'b0);
        check_frame("f0F", 8'h0F, 1'b1, 1'b0);

        // Break: line held low for several frame times.
        snap();
        rx_uart = 1'b0;
        tick(3 * (NB + 2) * BD);
        chk("brk.ferr", n_ferr - s_ferr, 32'd1);
        chk("brk.vld",  n_vld - s_vld, 32'd0);
        chk("brk.busy", 32'(busy), 32'd0);
        chk("brk.data", 32'(rx_data), 32'(exp_data));
        rx_uart = 1'b1;
        tick(BD);

        send(8'h81, 1'b0, 1'b0);
        check_frame("f81_ferr", 8'h81, 1'b0, 1'b0);
        rx_uart = 1'b1;
        tick(2);

        // Reset pulse in the middle of the fourth data bit of 0xFF.
        snap();
        rx_uart = 1'b0;
        tick(BD);
        rx_uart = 1'b1;
        tick(3 * BD + H);
        chk("mid.busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_data = '0;
        chk("mid.data", 32'(rx_data), 32'd0);
        chk("mid.led",  32'(led), 32'd0);
        chk("mid.busy", 32'(busy), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick((NB - 3) * BD + BD);
        chk("mid.strobes", (n_vld - s_vld) + (n_ferr - s_ferr) + (n_perr - s_perr), 32'd0);
        send(8'h12, 1'b1, 1'b0);
        check_frame("f12", 8'h12, 1'b1, 1'b0);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b0);
        check_frame("par_ok", 8'h07, 1'b1, 1'b0);
        send(8'h07, 1'b1, 1'b1);
        check_frame("par_bad", 8'h07, 1'b1, 1'b1);
`endif

        // Random frames with random gaps, bad stop bits and (if built) bad parity.
        prev_stop = 1'b1;
        for (int k = 0; k < 14; k++) begin
            d    = DATA_W'($urandom);
            stop = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            flip = ($urandom_range(0, 3) == 0);
`else
            flip = 1'b0;
`endif
            gap = $urandom_range(0, 3);
            if (!prev_stop && gap < 2) gap = 2;
            if (gap > 0) begin
                rx_uart = 1'b1;
                tick(gap);
            end
            send(d, stop, flip);
            check_frame("rnd", d, stop, flip);
            prev_stop = stop;
        end
        rx_uart = 1'b1;
        tick(BD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
